// File: rtl/r_tile_write_queue_pkg.sv
// Local widths and helpers for the R-tile write queue.
package r_tile_write_queue_pkg;
   localparam int unsigned REG_ENTRIES = 32;
   localparam int unsigned TAG_W       = 5;
   localparam int unsigned ENC_W       = 32;
   localparam int unsigned IDX_W       = 5;
   localparam int unsigned CNT_W       = 6;

   function automatic logic [CNT_W-1:0] popcount32(input logic [ENC_W-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(ENC_W); i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction
endpackage

// File: rtl/trips_params.sv
// Shared TRIPS configuration constants used by the register tiles.
package trips_params;
   localparam int unsigned NUM_BANKS = 4;
   localparam int unsigned WQ_DEPTH  = 32;
endpackage

// File: rtl/trips_types.sv
// Shared TRIPS types: register payload and R-tile write-queue FSM state.
package trips_types;
   localparam int unsigned REG_DATA_W = 64;

   typedef logic [REG_DATA_W-1:0] reg_data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } rwq_state_e;
endpackage

// File: rtl/rwq_prio_enc.sv
// 32-bit lowest-set-bit priority encoder with an any-set flag.
module rwq_prio_enc
   import r_tile_write_queue_pkg::*;
(
   input  logic [ENC_W-1:0] req,
   output logic [IDX_W-1:0] idx_c,
   output logic             any_c
);

   // Descending scan so the lowest set bit is the final assignment.
   always_comb begin
      idx_c = '0;
      for (int i = int'(ENC_W) - 1; i >= 0; i--) begin
         if (req[i]) idx_c = IDX_W'(i);
      end
   end

   assign any_c = |req;

endmodule

// File: rtl/r_tile_write_queue.sv
// R-tile register bank with a speculative W queue: buffers writes, answers reads, drains on commit.
// Optional RWQ_FORWARD_EN: reads return the highest-slot queued value matching the register.
module r_tile_write_queue
   import trips_types::*;
   import r_tile_write_queue_pkg::*;
#(
   parameter int unsigned BANK_ID  = 0,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned WQ_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_req,
   input  logic [6:0]        reg_id,
   input  logic [4:0]        queue_id,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read_req,
   output logic              ack_reg,
   output logic              alignment_err,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   input  logic              commit_req,
   output logic              commit_ack,
   input  logic              flush,
   output logic [CNT_W-1:0]  wq_count
);

   logic [DATA_W-1:0]   regs    [REG_ENTRIES];
   logic [DATA_W-1:0]   wq_data [WQ_DEPTH];
   logic [TAG_W-1:0]    wq_tag  [WQ_DEPTH];
   logic [WQ_DEPTH-1:0] wq_valid;
   logic [WQ_DEPTH-1:0] valid_next;
   rwq_state_e          state;
   rwq_state_e          state_next;

   logic              bank_hit_c;
   logic              write_en_c;
   logic              drain_en_c;
   logic              commit_ack_next_c;
   logic [TAG_W-1:0]  tag_c;
   logic [ENC_W-1:0]  drain_req_c;
   logic [IDX_W-1:0]  drain_idx_c;
   logic              drain_any_c;
   logic [DATA_W-1:0] read_word_c;

   assign bank_hit_c  = (reg_id[1:0] == 2'(BANK_ID));
   assign tag_c       = reg_id[6:2];
   assign drain_req_c = ENC_W'(wq_valid);

   rwq_prio_enc u_drain_enc (
      .req   (drain_req_c),
      .idx_c (drain_idx_c),
      .any_c (drain_any_c)
   );

`ifdef RWQ_FORWARD_EN
   logic [ENC_W-1:0] fwd_rev_c;
   logic [IDX_W-1:0] fwd_rev_idx_c;
   logic             fwd_any_c;

   // Bit-reversed match vector: the lowest set bit is the highest matching slot.
   always_comb begin
      fwd_rev_c = '0;
      for (int i = 0; i < int'(WQ_DEPTH); i++) begin
         fwd_rev_c[int'(ENC_W) - 1 - i] = wq_valid[i] && (wq_tag[i] == tag_c);
      end
   end

   rwq_prio_enc u_fwd_enc (
      .req   (fwd_rev_c),
      .idx_c (fwd_rev_idx_c),
      .any_c (fwd_any_c)
   );

   always_comb begin
      read_word_c = regs[tag_c];
      if (fwd_any_c) read_word_c = wq_data[IDX_W'(ENC_W - 1) - fwd_rev_idx_c];
   end
`else
   assign read_word_c = regs[tag_c];
`endif

   // Next-state, queue-valid update and commit handshake; flush overrides everything.
   always_comb begin
      state_next        = state;
      valid_next        = wq_valid;
      drain_en_c        = 1'b0;
      commit_ack_next_c = 1'b0;
      write_en_c        = write_req && bank_hit_c && (state == IDLE) && !flush;

      if (write_en_c) valid_next[queue_id] = 1'b1;

      case (state)
         IDLE: begin
            // commit_ack high means the requester is still releasing the last commit.
            if (commit_req && !commit_ack) state_next = (|valid_next) ? DRAIN : DONE;
         end
         DRAIN: begin
            drain_en_c              = drain_any_c;
            valid_next[drain_idx_c] = 1'b0;
            if (valid_next == '0) begin
               state_next        = DONE;
               commit_ack_next_c = 1'b1;
            end
         end
         DONE: begin
            state_next        = IDLE;
            commit_ack_next_c = !commit_ack;
         end
         default: state_next = IDLE;
      endcase

      if (flush) begin
         valid_next        = '0;
         state_next        = IDLE;
         drain_en_c        = 1'b0;
         commit_ack_next_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wq_valid      <= '0;
         wq_count      <= '0;
         ack_reg       <= 1'b0;
         alignment_err <= 1'b0;
         read_valid    <= 1'b0;
         read_data     <= '0;
         commit_ack    <= 1'b0;
      end else begin
         state         <= state_next;
         wq_valid      <= valid_next;
         wq_count      <= popcount32(ENC_W'(valid_next));
         ack_reg       <= write_en_c;
         alignment_err <= (read_req || write_req) && !bank_hit_c;
         read_valid    <= read_req && bank_hit_c;
         commit_ack    <= commit_ack_next_c;
         if (read_req && bank_hit_c) read_data <= read_word_c;
      end
   end

   // Queue payload needs no reset; wq_valid qualifies every use.
   always_ff @(posedge clk) begin
      if (write_en_c) begin
         wq_data[queue_id] <= write_data;
         wq_tag[queue_id]  <= tag_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(REG_ENTRIES); i++) regs[i] <= '0;
      end else if (drain_en_c) begin
         regs[wq_tag[drain_idx_c]] <= wq_data[drain_idx_c];
      end
   end

endmodule

// File: doc/r_tile_write_queue.md
# r_tile_write_queue

Register-bank responder for E-tile register traffic; the receiving end of the E-tile `read_req`/`write_req`/`ack_reg` interface. Holds one of four interleaved architectural register banks (32 of G[0-127], selected by `reg_id[1:0]`) plus the 32-entry W queue (W[0-31]) for the in-flight block. Buffers speculative writes, answers register reads, drains the queue into the bank on block commit, and discards it on flush.

## Interface
Parameters:
- `BANK_ID`, 0: bank index; owns registers with `reg_id[1:0] == BANK_ID`.
- `DATA_W`, 64: width of `reg_data_t`.
- `WQ_DEPTH`, 32: W-queue entries, indexed by `queue_id`.

Ports (one clock; reset asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `write_req` in 1: write request from E-tile.
- `reg_id` in 7: architectural register G[0-127].
- `queue_id` in 5: W-queue slot.
- `write_data` in DATA_W: write value.
- `read_req` in 1: read request.
- `ack_reg` out 1: write accepted.
- `alignment_err` out 1: request addressed another bank.
- `read_data` out DATA_W: read result.
- `read_valid` out 1: `read_data` valid.
- `commit_req` in 1: block commit from G-tile, level until `commit_ack`.
- `commit_ack` out 1: drain complete.
- `flush` in 1: discard queue (misspeculation).
- `wq_count` out 6: number of valid queue entries.

## Operation
- Storage: `regs[32]` indexed by `reg_id[6:2]`; per-slot `wq_valid`, `wq_tag[4:0]` (`reg_id[6:2]`), `wq_data`.
- FSM states:
  - IDLE, on `commit_req`: go to DRAIN, or to DONE when no slot is valid.
  - DRAIN: each cycle, write the lowest-index valid slot into `regs[tag]` and clear its valid bit. Go to DONE in the cycle the last valid slot drains.
  - DONE: `commit_ack`=1 for one cycle, then go to IDLE.
- Writes, IDLE only:
  - Correct bank: `wq_data[queue_id]` <= `write_data`, tag <= `reg_id[6:2]`, valid <= 1.
  - Rewriting a valid slot overwrites it; last write wins and `wq_count` is unchanged.
  - In DRAIN or DONE, writes are refused (no ack); the requester retries.
- Wrong bank (`reg_id[1:0] != BANK_ID`) on either request: no state change, `alignment_err` pulses.
- Reads, any state: return `regs[reg_id[6:2]]`.
- Simultaneous `read_req` and `write_req`: both are serviced; the read sees pre-write state.
- Flush, any state: clear all `wq_valid`, go to IDLE, no `commit_ack`.
  - Slots already drained stay committed.
  - Flush beats a same-cycle write and a same-cycle `commit_req`.
- `wq_count`: popcount of `wq_valid`, registered.

## Timing
- Reset values: all outputs 0; `wq_valid` 0; `regs` 0; FSM in IDLE.
- `ack_reg`, `alignment_err`, `read_valid`: registered, one-cycle pulse in the cycle after the request.
- `read_data`: registered, valid with `read_valid`; holds its last value otherwise.
- Commit latency from the first `commit_req` cycle:
  - N valid slots: N cycles in DRAIN, then `commit_ack` in the next cycle.
  - N=0: `commit_ack` 2 cycles after `commit_req`.
- A write accepted in the same cycle `commit_req` is first seen is included in the drain.
- Reset mid-drain: queue lost, partial commits lost (regs reset).

## Configuration
- `RWQ_FORWARD_EN` defined:
  - A read whose `reg_id[6:2]` matches a valid slot tag returns that slot's data.
  - If several slots match, the highest `queue_id` wins.
  - Same latency as a non-forwarded read.
- Undefined: reads always return `regs`, and queued values are invisible until commit.

## Structure
- Shared package `trips_types`: `reg_data_t`, `rwq_state_e` {IDLE, DRAIN, DONE}.
- Shared package `trips_params`: `NUM_BANKS`=4, `WQ_DEPTH`.
- One sub-module: `rwq_prio_enc`, a 32-bit lowest-set-bit priority encoder with any-flag. It selects the drain slot and, reused in reverse order, the forwarding match.

## Test plan
- Write G5 (bank 1, `BANK_ID`=1) of 0xAB to slot 3 → `ack_reg` next cycle, `wq_count`=1; read G5 → 0 without `RWQ_FORWARD_EN`, 0xAB with it.
- Write G4 with `BANK_ID`=1 → `alignment_err` pulse, no `ack_reg`, `wq_count` stays 0.
- Fill slots 0, 7 and 31 (G1, G5, G9), assert `commit_req` → 3 DRAIN cycles, `commit_ack` in cycle 4, subsequent reads return the written values, `wq_count`=0.
- Slot 2 written twice (0x11, then 0x22) to G13, then commit → G13=0x22.
- Flush in the second DRAIN cycle with 4 valid slots → slot 0 committed, others discarded, no `commit_ack`, IDLE.
- `commit_req` with an empty queue → `commit_ack` 2 cycles later; `write_req` during DONE → no ack until IDLE.
